// File: rtl/aes_pkg.sv
// Shared AES decrypt-datapath types, constants and helpers.
package aes_pkg;

  localparam int unsigned AES_ROUNDS = 10;
  localparam int unsigned STATE_W    = 128;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NUM_BYTES  = STATE_W / BYTE_W;
  localparam int unsigned ROUND_W    = $clog2(AES_ROUNDS + 1);

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [ROUND_W-1:0] round_t;

  // One pipeline stage payload: data word, the key that travels with it, and tags.
  typedef struct packed {
    state_t data;
    state_t key;
    round_t round;
    logic   last;
  } stage_t;

  // Inverse S-box, indexed by the input byte.
  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // InvShiftRows: row r rotates right by r columns, out(r,c) = in(r,(c-r) mod 4).
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[32*c + 8*r +: 8] = s[32*((c - r + 4) % 4) + 8*r +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Single-byte AES inverse S-box lookup (combinational).
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] in_byte,
  output logic [BYTE_W-1:0] out_byte
);

  assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_round_sub_shift_stage.sv
// AES-128 inverse-round front end: InvShiftRows -> InvSubBytes -> AddRoundKey,
// elastic valid/ready pipeline. Define AES_INV_EXTRA_PIPE_EN to insert an extra
// register (S0) between InvShiftRows and InvSubBytes (latency 3 instead of 2).
module inv_round_sub_shift_stage
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] in_round_key,
  input  logic [ROUND_W-1:0] in_round,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic [ROUND_W-1:0] out_round,
  output logic               out_last
);

  stage_t       up_q;
  logic         up_v;
  stage_t       s1_d;
  stage_t       s1_q;
  logic         s1_v;
  logic         s1_adv;
  state_t       s2_data;
  round_t       s2_round;
  logic         s2_last;
  logic         s2_v;
  logic         s2_adv;
  state_t       sub_out;

  // Elastic advance chain: a stage may load when empty or when its successor moves.
  assign s2_adv = ~s2_v | out_ready;
  assign s1_adv = ~s1_v | s2_adv;

`ifdef AES_INV_EXTRA_PIPE_EN
  stage_t s0_q;
  logic   s0_v;
  logic   s0_adv;

  assign s0_adv   = ~s0_v | s1_adv;
  assign in_ready = s0_adv & ~flush;
  assign up_q     = s0_q;
  assign up_v     = s0_v;

  // S0: registers the InvShiftRows result with key and tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v <= 1'b0;
      s0_q <= '0;
    end else if (flush) begin
      s0_v <= 1'b0;
    end else if (s0_adv) begin
      s0_v <= in_valid;
      if (in_valid) begin
        s0_q <= '{data: inv_shift_rows(in_state), key: in_round_key,
                  round: in_round, last: in_last};
      end
    end
  end
`else
  assign in_ready = s1_adv & ~flush;
  assign up_q     = '{data: inv_shift_rows(in_state), key: in_round_key,
                      round: in_round, last: in_last};
  assign up_v     = in_valid;
`endif

  // InvSubBytes on all 16 bytes of the shifted state.
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .in_byte  (up_q.data[BYTE_W*i +: BYTE_W]),
      .out_byte (sub_out[BYTE_W*i +: BYTE_W])
    );
  end

  assign s1_d = '{data: sub_out, key: up_q.key, round: up_q.round, last: up_q.last};

  // S1: substituted state plus the key still to be added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= up_v;
      if (up_v) begin
        s1_q <= s1_d;
      end
    end
  end

  // S2: AddRoundKey result; drives the output ports directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      s2_data  <= '0;
      s2_round <= '0;
      s2_last  <= 1'b0;
    end else if (flush) begin
      s2_v <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data  <= s1_q.data ^ s1_q.key;
        s2_round <= s1_q.round;
        s2_last  <= s1_q.last;
      end
    end
  end

  assign out_valid = s2_v;
  assign out_state = s2_data;
  assign out_round = s2_round;
  assign out_last  = s2_last;

endmodule
